op_packet_scheduler: RTL
========================

# op_packet_scheduler

Sequences outbound opcode packets onto the shared 40-bit transmit path toward the monitor link serializer. Three requesters share that path: audio-sample requests, the power-on packet, and keyboard/mouse reply packets. The block holds pending requests, arbitrates by fixed priority, and presents one packet at a time with a valid/ready handshake. It waits for the serializer's completion pulse, then enforces a programmable idle gap before the next packet.

## Interface
- GAP_CYCLES, 16, idle cycles inserted after each packet completes (0 = no gap)
- KBD_OPCODE, 8'hC5, opcode byte prefixed to keyboard reply payloads
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- audio_req  in  1  one-cycle pulse: request an audio sample packet
- power_on_req  in  1  one-cycle pulse: request the power-on packet
- kbd_reply_valid  in  1  keyboard reply payload offered
- kbd_reply_data  in  32  keyboard reply payload
- kbd_reply_ready  out  1  one-entry keyboard buffer empty
- tx_data  out  40  packet to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts packet
- tx_done  in  1  one-cycle pulse: serializer finished shifting the packet
- busy  out  1  FSM not in IDLE
- audio_overrun  out  1  one-cycle pulse: audio request merged into an already pending one

## Operation
- Packet encodings:
  - audio: 40'h07_0000_0000
  - power-on: 40'hC6_7100_0000
  - keyboard: {KBD_OPCODE, kbd_reply_data}
- Pending flags audio_pend and power_pend:
  - Set on the respective request pulse.
  - Cleared when the packet of that source is accepted (tx_valid && tx_ready).
  - Request in the same cycle as its own clear: flag stays set, and a second packet is sent later.
- audio_overrun pulses when audio_req arrives while audio_pend=1 and audio_pend is not being cleared that cycle. The requests merge into one packet.
- Keyboard buffer:
  - kbd_reply_ready = ~kbd_full (combinational).
  - Payload captured on kbd_reply_valid && kbd_reply_ready.
  - kbd_full clears on acceptance of the keyboard packet.
- Priority: audio > power-on > keyboard.
- FSM states:
  - IDLE:
    - Any pending source (registered flags) → OFFER.
    - On that transition, latch the winner's packet into tx_data and record its source.
  - OFFER:
    - tx_valid=1; tx_data is held stable.
    - No re-arbitration, even if a higher-priority request arrives.
    - tx_ready=1 → WAIT_DONE; the source's pending flag/buffer clears on the same edge.
  - WAIT_DONE: tx_valid=0. tx_done → GAP, or → IDLE if GAP_CYCLES=0.
  - GAP: down-counter loaded with GAP_CYCLES-1; → IDLE when the counter is 0.
- tx_done is ignored outside WAIT_DONE.
- Gap counter width is $clog2(GAP_CYCLES+1), minimum 1 bit.
- Requests and keyboard captures are accepted in every state; they wait as pending.

## Timing
- Reset values (asynchronous, while rst=1):
  - FSM IDLE; all flags and kbd_full cleared; gap counter 0.
  - tx_data=0, tx_valid=0, busy=0, audio_overrun=0.
  - kbd_reply_ready=1.
- Request pulse sampled at edge N → pending set at N. Edge N+1 enters OFFER. tx_valid is high from N+1 until the accepting edge.
- tx_valid and tx_data are registered. tx_valid deasserts the cycle after the accepting edge.
- tx_done sampled at edge M → GAP from M. Earliest next OFFER is at edge M+GAP_CYCLES+1.
- busy is high in OFFER, WAIT_DONE and GAP.
- audio_overrun is registered: it is high the cycle after the offending request edge.
- rst asserted mid-packet: all requests and buffered payloads are dropped, tx_valid drops immediately, and the FSM returns to IDLE.

## Test plan
- Audio only, GAP_CYCLES=4, tx_ready tied 1:
  - audio_req at edge 0 → tx_valid=1, tx_data=40'h0700000000 after edge 1, low after edge 2.
  - tx_done at edge 10 → busy falls after edge 14.
- Simultaneous audio_req, power_on_req and kbd payload 32'h12345678:
  - Packet order 0700000000, C671000000, C512345678.
  - Each packet is separated by tx_done plus the gap.
- Backpressure: hold tx_ready=0 for 20 cycles in OFFER while power_on_req arrives.
  - tx_data stays 0700000000 throughout.
  - Power-on packet follows after the audio packet completes.
- Overrun: two audio_req pulses while waiting in WAIT_DONE of a keyboard packet.
  - audio_overrun pulses once.
  - Exactly one audio packet is sent afterward.
- Keyboard backpressure: second kbd_reply_valid while the buffer is full.
  - kbd_reply_ready=0 until the first keyboard packet is accepted.
  - The second payload is captured on the next edge after that.
- Reset mid-OFFER with audio and keyboard pending:
  - All outputs return to their reset values during rst.
  - No packet is offered after release until a new request arrives.

Source files
------------

// File: rtl/op_packet_scheduler_if.sv
// Transmit path toward the monitor link serializer: one 40-bit packet
// per valid/ready handshake, then a completion pulse once it has been shifted out.
interface op_packet_scheduler_if;
  logic [39:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );
endinterface

// File: rtl/op_packet_scheduler.sv
// Fixed-priority scheduler (audio > power-on > keyboard) feeding opcode packets
// to the serializer, with a programmable idle gap after each completed packet.
module op_packet_scheduler #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  KBD_OPCODE = 8'hC5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 audio_req,
  input  logic                 power_on_req,
  input  logic                 kbd_reply_valid,
  input  logic [31:0]          kbd_reply_data,
  output logic                 kbd_reply_ready,
  op_packet_scheduler_if.master tx,
  output logic                 busy,
  output logic                 audio_overrun
);
  localparam int unsigned   CW        = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [39:0]   AUDIO_PKT = 40'h07_0000_0000;
  localparam logic [39:0]   POWER_PKT = 40'hC6_7100_0000;
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT_DONE, S_GAP} state_e;
  typedef enum logic [1:0] {SRC_AUDIO, SRC_POWER, SRC_KBD} src_e;

  state_e        state_q;
  src_e          src_q;
  src_e          win_src;
  logic [39:0]   win_pkt;
  logic [CW-1:0] gap_q;
  logic [39:0]   tx_data_q;
  logic          tx_valid_q, busy_q, audio_overrun_q;
  logic          audio_pend_q, power_pend_q, kbd_full_q;
  logic          audio_pend_d, power_pend_d, kbd_full_d, audio_overrun_d;
  logic [31:0]   kbd_data_q;
  logic          accept, audio_clr, power_clr, kbd_clr, kbd_capture, any_pend;

  assign kbd_reply_ready = ~kbd_full_q;
  assign tx.tx_data      = tx_data_q;
  assign tx.tx_valid     = tx_valid_q;
  assign busy            = busy_q;
  assign audio_overrun   = audio_overrun_q;

  always_comb begin
    accept      = tx_valid_q && tx.tx_ready;
    audio_clr   = accept && (src_q == SRC_AUDIO);
    power_clr   = accept && (src_q == SRC_POWER);
    kbd_clr     = accept && (src_q == SRC_KBD);
    kbd_capture = kbd_reply_valid && !kbd_full_q;
    // A request landing on its own clear edge re-arms the flag for a second packet.
    audio_pend_d    = audio_req    | (audio_pend_q & ~audio_clr);
    power_pend_d    = power_on_req | (power_pend_q & ~power_clr);
    kbd_full_d      = kbd_capture  | (kbd_full_q   & ~kbd_clr);
    audio_overrun_d = audio_req & audio_pend_q & ~audio_clr;
    any_pend        = audio_pend_q | power_pend_q | kbd_full_q;
    win_src = SRC_KBD;
    win_pkt = {KBD_OPCODE, kbd_data_q};
    if (audio_pend_q) begin
      win_src = SRC_AUDIO;
      win_pkt = AUDIO_PKT;
    end else if (power_pend_q) begin
      win_src = SRC_POWER;
      win_pkt = POWER_PKT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      src_q           <= SRC_AUDIO;
      gap_q           <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      audio_overrun_q <= 1'b0;
      audio_pend_q    <= 1'b0;
      power_pend_q    <= 1'b0;
      kbd_full_q      <= 1'b0;
      kbd_data_q      <= '0;
    end else begin
      audio_pend_q    <= audio_pend_d;
      power_pend_q    <= power_pend_d;
      kbd_full_q      <= kbd_full_d;
      audio_overrun_q <= audio_overrun_d;
      if (kbd_capture) kbd_data_q <= kbd_reply_data;
      case (state_q)
        S_IDLE: begin
          if (any_pend) begin
            state_q    <= S_OFFER;
            src_q      <= win_src;
            tx_data_q  <= win_pkt;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_OFFER: begin
          if (tx.tx_ready) begin
            state_q    <= S_WAIT_DONE;
            tx_valid_q <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (tx.tx_done) begin
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
